// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, and a
// word-by-word refill FSM that fetches one line from external memory on a miss.
module icache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] pc_in,
    input  logic        invalidate,
    output logic [31:0] inst_out,
    output logic        IStall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [0:LINES-1];
    logic [31:0]            r_data [0:LINES*WORDS-1];
    logic [TAG_W-1:0]       r_base_tag;
    logic [IDX_W-1:0]       r_base_idx;
    logic [OFF_W-1:0]       r_cnt;
    logic [31:0]            r_hit_cnt;
    logic [31:0]            r_miss_cnt;

    logic [OFF_W-1:0]       w_off;
    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_last;
    logic                   w_count_hit;
    logic                   w_start_refill;
    logic                   w_fill;
    logic                   w_unused;

    assign w_off    = pc_in[OFF_W+1:2];
    assign w_idx    = pc_in[OFF_W+2 +: IDX_W];
    assign w_tag    = pc_in[31 -: TAG_W];
    assign w_unused = ^pc_in[1:0];
    // A pending fence.i forces a miss even when the line looks valid.
    assign w_hit    = req && !invalidate && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last   = (r_cnt == OFF_W'(WORDS - 1));

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, fetch outputs and refill handshake
    always_comb begin
        w_next_state   = r_state;
        inst_out       = NOP;
        IStall         = 1'b0;
        mem_req        = 1'b0;
        mem_addr       = 32'h0000_0000;
        w_count_hit    = 1'b0;
        w_start_refill = 1'b0;
        w_fill         = 1'b0;
        if (rst) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req && w_hit) begin
                        inst_out    = r_data[{w_idx, w_off}];
                        w_count_hit = 1'b1;
                    end else if (req) begin
                        IStall         = 1'b1;
                        w_start_refill = 1'b1;
                        w_next_state   = S_REFILL;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_REFILL: begin
                    IStall   = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {r_base_tag, r_base_idx, r_cnt, 2'b00};
                    if (invalidate) begin
                        w_next_state = S_IDLE;
                    end else if (mem_ack) begin
                        w_fill       = 1'b1;
                        w_next_state = w_last ? S_IDLE : S_REFILL;
                    end else begin
                        w_next_state = S_REFILL;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Valid bits, refill bookkeeping and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= {LINES{1'b0}};
            r_cnt      <= {OFF_W{1'b0}};
            r_base_tag <= {TAG_W{1'b0}};
            r_base_idx <= {IDX_W{1'b0}};
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else begin
            if (invalidate) begin
                r_valid <= {LINES{1'b0}};
            end else if (w_fill && w_last) begin
                r_valid[r_base_idx] <= 1'b1;
            end else begin
                r_valid <= r_valid;
            end
            if (w_count_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_hit_cnt <= r_hit_cnt;
            end
            if (w_start_refill) begin
                r_base_tag <= w_tag;
                r_base_idx <= w_idx;
                r_cnt      <= {OFF_W{1'b0}};
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end else if (w_fill) begin
                r_cnt <= r_cnt + OFF_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Tag and data arrays; contents are qualified by r_valid so they need no reset
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_data[{r_base_idx, r_cnt}] <= mem_rdata;
            if (w_last) begin
                r_tag[r_base_idx] <= r_base_tag;
            end
        end
    end

endmodule
